// File: rtl/pwm_bridge_decoder.sv
// pwm_bridge_decoder: per-carrier-period decoder for one H-bridge PWM pair.
// Reports leg on-times, net bridge volt-time, short pulses, edge bursts and sync loss.
module pwm_bridge_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] PERIOD_MAX  = 16'd4000,
    parameter logic [3:0]  EDGE_MAX    = 4'd4
) (
    input  logic               clk_20M,
    input  logic               reset_n,
    input  logic               Syn,
    input  logic               PWM_left,
    input  logic               PWM_right,
    input  logic [15:0]        PulWidth_Min,
    output logic [15:0]        OnTimeLeft,
    output logic [15:0]        OnTimeRight,
    output logic signed [16:0] NetTime,
    output logic               Data_valid,
    output logic               MinWidthErr,
    output logic               EdgeErr,
    output logic               SyncLost
);

    typedef enum logic {S_IDLE, S_MEAS} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_syncL;
    logic [SYNC_STAGES-1:0] r_syncR;
    logic                   r_sLd;
    logic                   r_sRd;
    logic [15:0]            r_per;
    logic [15:0]            r_onL;
    logic [15:0]            r_onR;
    logic [15:0]            r_wL;
    logic [15:0]            r_wR;
    logic signed [16:0]     r_net;
    logic [3:0]             r_eL;
    logic [3:0]             r_eR;
    logic                   r_minFlag;

    logic w_sL;
    logic w_sR;
    logic w_riseL;
    logic w_riseR;
    logic w_shortL;
    logic w_shortR;
    logic w_up;
    logic w_dn;
    logic w_last;
    logic w_run;
    logic w_timeout;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic signed [16:0] net_step(
        input logic signed [16:0] v,
        input logic               up,
        input logic               dn
    );
        logic signed [16:0] r;
        r = v;
        if (up && v != 17'sd65535)
            r = v + 17'sd1;
        else if (dn && v != -17'sd65535)
            r = v - 17'sd1;
        return r;
    endfunction

    assign w_sL     = r_syncL[SYNC_STAGES-1];
    assign w_sR     = r_syncR[SYNC_STAGES-1];
    assign w_riseL  = w_sL & ~r_sLd;
    assign w_riseR  = w_sR & ~r_sRd;
    // A fall with zero width means the pulse began before measurement started.
    assign w_shortL = ~w_sL & r_sLd & (r_wL != 16'd0) & (r_wL < PulWidth_Min);
    assign w_shortR = ~w_sR & r_sRd & (r_wR != 16'd0) & (r_wR < PulWidth_Min);
    assign w_up     = w_sL & ~w_sR;
    assign w_dn     = ~w_sL & w_sR;
    assign w_last   = (r_per == PERIOD_MAX - 16'd1);
    assign w_run    = (r_state == S_MEAS) & ~Syn & ~w_last;
    assign w_timeout = (r_state == S_MEAS) & ~Syn & w_last;

    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_syncL <= '0;
            r_syncR <= '0;
            r_sLd   <= 1'b0;
            r_sRd   <= 1'b0;
        end else begin
            r_syncL <= {r_syncL[SYNC_STAGES-2:0], PWM_left};
            r_syncR <= {r_syncR[SYNC_STAGES-2:0], PWM_right};
            r_sLd   <= w_sL;
            r_sRd   <= w_sR;
        end
    end

    // Syn restarts the accumulators from the Syn-cycle sample itself.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_per     <= '0;
            r_onL     <= '0;
            r_onR     <= '0;
            r_net     <= '0;
            r_eL      <= '0;
            r_eR      <= '0;
            r_wL      <= '0;
            r_wR      <= '0;
            r_minFlag <= 1'b0;
        end else if (Syn) begin
            r_per     <= 16'd1;
            r_onL     <= {15'd0, w_sL};
            r_onR     <= {15'd0, w_sR};
            r_net     <= net_step(17'sd0, w_up, w_dn);
            r_eL      <= {3'd0, w_riseL};
            r_eR      <= {3'd0, w_riseR};
            r_wL      <= w_sL ? sat16(r_wL) : 16'd0;
            r_wR      <= w_sR ? sat16(r_wR) : 16'd0;
            r_minFlag <= 1'b0;
        end else if (w_run) begin
            r_per     <= sat16(r_per);
            r_onL     <= w_sL ? sat16(r_onL) : r_onL;
            r_onR     <= w_sR ? sat16(r_onR) : r_onR;
            r_net     <= net_step(r_net, w_up, w_dn);
            r_eL      <= w_riseL ? sat4(r_eL) : r_eL;
            r_eR      <= w_riseR ? sat4(r_eR) : r_eR;
            r_wL      <= w_sL ? sat16(r_wL) : 16'd0;
            r_wR      <= w_sR ? sat16(r_wR) : 16'd0;
            r_minFlag <= r_minFlag | w_shortL | w_shortR;
        end else begin
            r_per     <= '0;
            r_onL     <= '0;
            r_onR     <= '0;
            r_net     <= '0;
            r_eL      <= '0;
            r_eR      <= '0;
            r_wL      <= '0;
            r_wR      <= '0;
            r_minFlag <= 1'b0;
        end
    end

    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            OnTimeLeft  <= '0;
            OnTimeRight <= '0;
            NetTime     <= '0;
            Data_valid  <= 1'b0;
            MinWidthErr <= 1'b0;
            EdgeErr     <= 1'b0;
            SyncLost    <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (Syn) begin
                        r_state  <= S_MEAS;
                        SyncLost <= 1'b0;
                    end
                end
                S_MEAS: begin
                    if (Syn) begin
                        OnTimeLeft  <= r_onL;
                        OnTimeRight <= r_onR;
                        NetTime     <= r_net;
                        MinWidthErr <= r_minFlag | w_shortL | w_shortR;
                        EdgeErr     <= (r_eL > EDGE_MAX) | (r_eR > EDGE_MAX);
                        Data_valid  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        SyncLost <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
